dtc_walker_engine: RTL and testbench

//  Programmable, sequential decision-tree classifier; successor to the fixed combinational dtc_* trees.

---
 rtl/dtc_walker_engine.sv | 139 +++++++++++++
 tb/tb_dtc_walker_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dtc_walker_engine.sv
// dtc_walker_engine: programmable decision-tree classifier.
// The tree lives in a writable node table and is walked one level per clock.
// Internal nodes test one latched feature bit and pick a child address.
// Leaf nodes return a class code. A walk that reaches MAX_DEPTH internal
// nodes stops with an error, so cycles in the table can never hang the engine.
module dtc_walker_engine #(
  parameter int N_FEAT    = 8,
  parameter int OUT_W     = 7,
  parameter int AW        = 6,
  parameter int MAX_DEPTH = 8,
  localparam int FIDX_W   = $clog2(N_FEAT),
  localparam int NODE_W   = 1 + (((FIDX_W + 2*AW) > OUT_W) ? (FIDX_W + 2*AW) : OUT_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_FEAT-1:0] inp,
  output logic [OUT_W-1:0]  outp,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [NODE_W-1:0] cfg_wdata,
  output logic              cfg_ready
);

  localparam int DEPTH   = 2**AW;
  localparam int DEPTH_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int FPAD    = 2**FIDX_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WALK   = 2'd1;
  localparam logic [1:0] S_RESULT = 2'd2;

  logic [1:0]         state;
  logic [N_FEAT-1:0]  feat;
  logic [AW-1:0]      cur;
  logic [DEPTH_W-1:0] depth;

  logic [NODE_W-1:0]  node_mem [DEPTH];
  logic               write_en;

  logic [NODE_W-1:0]  node;
  logic               is_int;
  logic [FIDX_W-1:0]  fidx;
  logic [AW-1:0]      hi_addr;
  logic [AW-1:0]      lo_addr;
  logic [OUT_W-1:0]   code;
  logic [FPAD-1:0]    feat_ext;
  logic [AW-1:0]      next_cur;

  assign in_ready  = (state == S_IDLE);
  assign cfg_ready = (state == S_IDLE);
  assign out_valid = (state == S_RESULT);

  // Table writes only land while idle; anything else is dropped.
  assign write_en = cfg_we && (state == S_IDLE);

  // Each table entry is its own register so the whole table clears on reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Entry gi: clear to leaf/code 0 on reset, load on an addressed write.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          node_mem[gi] <= '0;
        end else if (write_en && (cfg_addr == AW'(gi))) begin
          node_mem[gi] <= cfg_wdata;
        end
      end
    end
  endgenerate

  // Combinational read of the node currently being visited.
  assign node    = node_mem[cur];
  assign is_int  = node[NODE_W-1];
  assign fidx    = node[FIDX_W+2*AW-1:2*AW];
  assign hi_addr = node[2*AW-1:AW];
  assign lo_addr = node[AW-1:0];
  assign code    = node[OUT_W-1:0];

  // Pad the feature vector so a feature index past N_FEAT reads as 0.
  generate
    for (genvar gi = 0; gi < FPAD; gi++) begin : g_feat
      if (gi < N_FEAT) begin : g_real
        assign feat_ext[gi] = feat[gi];
      end else begin : g_pad
        assign feat_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign next_cur = feat_ext[fidx] ? hi_addr : lo_addr;

  // Walk control: accept a vector, step one level per cycle, hold the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      feat    <= '0;
      cur     <= '0;
      depth   <= '0;
      outp    <= '0;
      out_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            feat  <= inp;
            cur   <= '0;
            depth <= '0;
            state <= S_WALK;
          end
        end
        S_WALK: begin
          if (!is_int) begin
            outp    <= code;
            out_err <= 1'b0;
            state   <= S_RESULT;
          end else if (depth == DEPTH_W'(MAX_DEPTH - 1)) begin
            outp    <= '0;
            out_err <= 1'b1;
            state   <= S_RESULT;
          end else begin
            cur   <= next_cur;
            depth <= depth + DEPTH_W'(1);
          end
        end
        S_RESULT: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtc_walker_engine.sv
// Bench for dtc_walker_engine: directed scenarios followed by random trees,
// every result compared against a table-walking reference model.
// Latency is counted in clock edges with the accept edge itself as edge 1.
module tb_dtc_walker_engine;

  localparam int N_FEAT    = 8;
  localparam int OUT_W     = 7;
  localparam int AW        = 6;
  localparam int MAX_DEPTH = 8;
  localparam int NODE_W    = 16;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [N_FEAT-1:0] inp;
  logic [OUT_W-1:0]  outp;
  logic              out_err;
  logic              out_valid;
  logic              out_ready;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [NODE_W-1:0] cfg_wdata;
  logic              cfg_ready;

  int checks = 0;
  int passes = 0;

  logic [NODE_W-1:0] model_mem [2**AW];

  dtc_walker_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp       (inp),
    .outp      (outp),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_ready (cfg_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: follow the table from the root, at most MAX_DEPTH internal nodes.
  function automatic void model_walk(input logic [N_FEAT-1:0] v, output logic [OUT_W-1:0] code,
                                     output logic err, output int lat);
    int a;
    logic [NODE_W-1:0] n;
    int f;
    a = 0;
    for (int d = 0; d < MAX_DEPTH; d++) begin
      n = model_mem[a];
      if (n[15] == 1'b0) begin
        code = n[6:0];
        err  = 1'b0;
        lat  = d + 2;
        return;
      end
      f = int'(n[14:12]);
      a = (f < N_FEAT && v[f]) ? int'(n[11:6]) : int'(n[5:0]);
    end
    code = '0;
    err  = 1'b1;
    lat  = MAX_DEPTH + 1;
  endfunction

  function automatic logic [NODE_W-1:0] mk_int(input int f, input int hi, input int lo);
    return {1'b1, 3'(f), 6'(hi), 6'(lo)};
  endfunction

  function automatic logic [NODE_W-1:0] mk_leaf(input int c);
    return {9'b0, 7'(c)};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2**AW; i++) model_mem[i] = '0;
  endtask

  task automatic cfg_write(input int a, input logic [NODE_W-1:0] d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(a);
    cfg_wdata = d;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    model_mem[a] = d;
  endtask

  // One classification: accept, wait bounded for out_valid, hold, release.
  task automatic run_vector(input string tag, input logic [N_FEAT-1:0] v, input int hold,
                            input bit mid_write);
    logic [OUT_W-1:0] ecode;
    logic eerr;
    int elat;
    int edges;
    model_walk(v, ecode, eerr, elat);
    @(negedge clk);
    check({tag, ".in_ready_idle"}, in_ready, 1);
    inp       = v;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    edges = 1;
    #1;
    in_valid = 1'b0;
    inp      = N_FEAT'($urandom);
    if (mid_write) begin
      cfg_we    = 1'b1;
      cfg_addr  = AW'(1);
      cfg_wdata = mk_leaf(7'h11);
    end
    while (edges < 30) begin
      @(negedge clk);
      if (mid_write && edges == 1) check({tag, ".cfg_ready_busy"}, cfg_ready, 0);
      if (out_valid) break;
      @(posedge clk);
      edges++;
      #1 cfg_we = 1'b0;
    end
    cfg_we = 1'b0;
    check({tag, ".latency"}, edges, elat);
    check({tag, ".outp"}, outp, ecode);
    check({tag, ".out_err"}, out_err, eerr);
    check({tag, ".in_ready_busy"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, ".hold_valid"}, out_valid, 1);
      check({tag, ".hold_outp"}, outp, ecode);
      check({tag, ".hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, ".valid_drop"}, out_valid, 0);
    check({tag, ".back_idle"}, in_ready, 1);
    $display("%s inp=%02h outp=%02h err=%0b lat=%0d", tag, v, outp, out_err, edges);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    inp       = '0;
    out_ready = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    model_clear();

    // T1: reset values, then an empty table classifies to 0
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t1.rst_in_ready", in_ready, 1);
    check("t1.rst_cfg_ready", cfg_ready, 1);
    check("t1.rst_out_valid", out_valid, 0);
    check("t1.rst_outp", outp, 0);
    check("t1.rst_out_err", out_err, 0);
    rst_n = 1'b1;
    run_vector("t1", 8'hFF, 0, 1'b0);

    // T2: three-node tree on feature 7
    cfg_write(0, mk_int(7, 2, 1));
    cfg_write(1, mk_leaf(7'h5B));
    cfg_write(2, mk_leaf(7'h37));
    run_vector("t2.hi", 8'h80, 0, 1'b0);
    run_vector("t2.lo", 8'h00, 0, 1'b0);

    // T3: self-loop at the root hits the depth limit
    cfg_write(0, mk_int(0, 0, 0));
    run_vector("t3", N_FEAT'($urandom), 0, 1'b0);

    // T4: backpressure holds the result
    cfg_write(0, mk_int(7, 2, 1));
    run_vector("t4", 8'h80, 5, 1'b0);

    // T5: table write while busy is dropped
    run_vector("t5.busy_wr", 8'h00, 0, 1'b1);
    run_vector("t5.after", 8'h00, 0, 1'b0);

    // T6: reset on the second walk cycle aborts and clears the table
    cfg_write(0, mk_int(0, 0, 0));
    @(negedge clk);
    inp      = 8'h01;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6.abort_valid", out_valid, 0);
    check("t6.abort_in_ready", in_ready, 1);
    check("t6.abort_outp", outp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    run_vector("t6.cleared", 8'h01, 0, 1'b0);

    // Random trees over the low 16 addresses, checked against the model
    for (int t = 0; t < 3; t++) begin
      for (int a = 0; a < 16; a++) begin
        if ($urandom_range(0, 99) < 55)
          cfg_write(a, mk_int($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15)));
        else
          cfg_write(a, {1'b0, 8'($urandom), 7'($urandom)});
      end
      for (int k = 0; k < 12; k++) begin
        run_vector($sformatf("rnd%0d.%0d", t, k), N_FEAT'($urandom), $urandom_range(0, 2), 1'b0);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
